// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handshake bundle.
// The memory stage is the master; wb_stage is the slave.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic [REG_AW-1:0] mem_dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_valid, mem_wb_en, mem_r_en,
        output mem_dest, alu_result, mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_wb_en, mem_r_en,
        input  mem_dest, alu_result, mem_data,
        output mem_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: buffers results in a small FIFO ahead of the regfile port.
// Optional macro WB_BYPASS_EN: empty-FIFO beats go straight to the port.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    wb_stage_if.slave         mem,
    input  logic              wb_hold,
    output logic              wirteBackEn,
    output logic [REG_AW-1:0] Dest_wb,
    output logic [DATA_W-1:0] Result_WB,
    output logic              pc_write_drop,
    output logic [2:0]        occupancy
);

    // Storage sized for the largest legal DEPTH so a 2-bit pointer always fits.
    logic [REG_AW-1:0] dest_q [4];
    logic [DATA_W-1:0] data_q [4];
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [2:0]        occ;

    logic              accept;
    logic              is_pc;
    logic              storable;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sel_val;

    assign mem.mem_ready = (occ < 3'(DEPTH));
    assign accept        = mem.mem_valid && mem.mem_ready;
    assign sel_val       = mem.mem_r_en ? mem.mem_data : mem.alu_result;
    assign is_pc         = (mem.mem_dest == REG_AW'(15));
    assign storable      = accept && mem.mem_wb_en && !is_pc;

`ifdef WB_BYPASS_EN
    assign bypass = storable && (occ == 3'd0) && !wb_hold;
`else
    assign bypass = 1'b0;
`endif

    assign push = storable && !bypass;
    assign pop  = (occ != 3'd0) && !wb_hold;

    always_comb begin
        wirteBackEn = pop || bypass;
        Dest_wb     = '0;
        Result_WB   = '0;
        if (occ != 3'd0) begin
            Dest_wb   = dest_q[rd_ptr];
            Result_WB = data_q[rd_ptr];
        end else if (bypass) begin
            Dest_wb   = mem.mem_dest;
            Result_WB = sel_val;
        end
    end

    assign occupancy = occ;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ           <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            pc_write_drop <= 1'b0;
        end else begin
            pc_write_drop <= accept && mem.mem_wb_en && is_pc;
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= mem.mem_dest;
            data_q[wr_ptr] <= sel_val;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (default build, DEPTH=2).
// A queue model is compared every cycle; directed literal checks pin it.
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb_hold = 1'b0;
    logic          wirteBackEn;
    logic [AW-1:0] Dest_wb;
    logic [DW-1:0] Result_WB;
    logic          pc_write_drop;
    logic [2:0]    occupancy;

    wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) mif ();

    wb_stage #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (mif.slave),
        .wb_hold       (wb_hold),
        .wirteBackEn   (wirteBackEn),
        .Dest_wb       (Dest_wb),
        .Result_WB     (Result_WB),
        .pc_write_drop (pc_write_drop),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } ent_t;

    ent_t m_q[$];
    ent_t wr_log[$];
    logic m_drop = 1'b0;
    bit   started = 1'b0;

    // Reference model: a plain queue updated from the inputs seen at each edge.
    always @(posedge clk) begin
        bit   rdy, pop, acc;
        ent_t e;
        started = 1'b1;
        if (!reset) begin
            m_q.delete();
            m_drop = 1'b0;
        end else begin
            rdy = (m_q.size() < DEPTH);
            pop = (m_q.size() != 0) && !wb_hold;
            acc = mif.mem_valid && rdy;
            m_drop = acc && mif.mem_wb_en && (mif.mem_dest == 4'd15);
            if (pop)
                void'(m_q.pop_front());
            if (acc && mif.mem_wb_en && mif.mem_dest != 4'd15) begin
                e.d = mif.mem_dest;
                e.v = mif.mem_r_en ? mif.mem_data : mif.alu_result;
                m_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (started) begin
            chk("occ", 32'(occupancy), 32'(m_q.size()));
            chk("ready", 32'(mif.mem_ready), 32'(m_q.size() < DEPTH));
            chk("wen", 32'(wirteBackEn), 32'(m_q.size() != 0 && !wb_hold));
            chk("dest", 32'(Dest_wb), m_q.size() != 0 ? 32'(m_q[0].d) : 32'd0);
            chk("data", Result_WB, m_q.size() != 0 ? m_q[0].v : 32'd0);
            chk("drop", 32'(pc_write_drop), 32'(m_drop));
            if (wirteBackEn === 1'b1) begin
                e.d = Dest_wb;
                e.v = Result_WB;
                wr_log.push_back(e);
            end
        end
    end

    task automatic beat(input logic v, input logic we, input logic re,
                        input logic [AW-1:0] d, input logic [DW-1:0] a,
                        input logic [DW-1:0] md);
        mif.mem_valid  = v;
        mif.mem_wb_en  = we;
        mif.mem_r_en   = re;
        mif.mem_dest   = d;
        mif.alu_result = a;
        mif.mem_data   = md;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] exp_d [11];
    logic [DW-1:0] exp_v [11];

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        chk("rst_wen", 32'(wirteBackEn), 32'd0);
        chk("rst_dest", 32'(Dest_wb), 32'd0);
        chk("rst_data", Result_WB, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(mif.mem_ready), 32'd1);

        cyc();
        beat(1, 1, 0, 4'd3, 32'h1234, 32'h0);
        cyc();
        idle();
        @(negedge clk);
        chk("alu_wen", 32'(wirteBackEn), 32'd1);
        chk("alu_dest", 32'(Dest_wb), 32'd3);
        chk("alu_data", Result_WB, 32'h1234);
        cyc();
        @(negedge clk);
        chk("alu_occ", 32'(occupancy), 32'd0);

        cyc();
        beat(1, 1, 1, 4'd7, 32'h40, 32'hDEADBEEF);
        cyc();
        idle();
        @(negedge clk);
        chk("ld_data", Result_WB, 32'hDEADBEEF);
        chk("ld_dest", 32'(Dest_wb), 32'd7);
        cyc();

        wb_hold = 1'b1;
        beat(1, 1, 0, 4'd1, 32'h11, 32'h0);
        cyc();
        beat(1, 1, 0, 4'd2, 32'h22, 32'h0);
        cyc();
        beat(1, 1, 0, 4'd3, 32'h33, 32'h0);
        cyc();
        @(negedge clk);
        chk("full_ready", 32'(mif.mem_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd2);
        chk("hold_wen", 32'(wirteBackEn), 32'd0);
        chk("hold_dest", 32'(Dest_wb), 32'd1);
        cyc();
        wb_hold = 1'b0;
        cyc();
        cyc();
        idle();
        @(negedge clk);
        chk("third_dest", 32'(Dest_wb), 32'd3);
        chk("third_occ", 32'(occupancy), 32'd1);
        cyc();

        beat(1, 1, 0, 4'd15, 32'h55, 32'h0);
        cyc();
        idle();
        @(negedge clk);
        chk("pc_drop", 32'(pc_write_drop), 32'd1);
        chk("pc_wen", 32'(wirteBackEn), 32'd0);
        cyc();
        @(negedge clk);
        chk("pc_drop_end", 32'(pc_write_drop), 32'd0);
        cyc();
        beat(1, 0, 0, 4'd5, 32'h66, 32'h0);
        cyc();
        idle();
        @(negedge clk);
        chk("nowb_occ", 32'(occupancy), 32'd0);
        chk("nowb_wen", 32'(wirteBackEn), 32'd0);
        cyc();

        // Back-to-back stream: push and pop together, pointers wrap.
        for (int i = 0; i < 6; i++) begin
            beat(1, 1, i[0], AW'(8 + i), 32'h100 + i, 32'h200 + i);
            cyc();
        end
        idle();
        cyc();
        cyc();

        wb_hold = 1'b1;
        beat(1, 1, 0, 4'd4, 32'h44, 32'h0);
        cyc();
        beat(1, 1, 0, 4'd6, 32'h66, 32'h0);
        cyc();
        idle();
        @(negedge clk);
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_wen", 32'(wirteBackEn), 32'd0);
        chk("mid_rst_dest", 32'(Dest_wb), 32'd0);
        chk("mid_rst_data", Result_WB, 32'd0);
        cyc();
        wb_hold = 1'b0;
        repeat (4) cyc();

        exp_d = '{4'd3, 4'd7, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10,
                  4'd11, 4'd12, 4'd13};
        exp_v = '{32'h1234, 32'hDEADBEEF, 32'h11, 32'h22, 32'h33,
                  32'h100, 32'h201, 32'h102, 32'h203, 32'h104, 32'h205};
        chk("log_len", 32'(wr_log.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < wr_log.size()) begin
                chk($sformatf("log%0d_d", i), 32'(wr_log[i].d), 32'(exp_d[i]));
                chk($sformatf("log%0d_v", i), wr_log[i].v, exp_v[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
